// File: rtl/signed_add_arb_if.sv
// rtl/signed_add_arb_if.sv - request/result bundle between two requesters, the shared add/sub arbiter and the result consumer
//
// Purpose: groups the two requester channels, the result channel and the
// completed-operation counter into one bundle.
// Modports:
//   master - requester/consumer side: drives reqN_valid/op/sgn/a/b and res_ready,
//            observes reqN_ready, res_valid/data/id/ovf and ops_cnt
//   slave  - arbiter side (signed_add_arb), the mirror image of master
// Parameters: W (operand/result width), CNT_W (ops_cnt width)

interface signed_add_arb_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_op;
    logic             req0_sgn;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_op;
    logic             req1_sgn;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic             res_id;
    logic             res_ovf;
    logic [CNT_W-1:0] ops_cnt;

    modport master (
        output req0_valid, req0_op, req0_sgn, req0_a, req0_b,
        output req1_valid, req1_op, req1_sgn, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, res_ovf, ops_cnt
    );

    modport slave (
        input  req0_valid, req0_op, req0_sgn, req0_a, req0_b,
        input  req1_valid, req1_op, req1_sgn, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, res_ovf, ops_cnt
    );
endinterface

// File: rtl/signed_add_arb.sv
// rtl/signed_add_arb.sv - round-robin arbiter and sequencer for one shared signed/unsigned add/sub unit
//
// Purpose: accepts operations from two valid/ready requesters, grants the
// shared adder round-robin, computes one result at a time and holds it in a
// result register until the consumer takes it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - signed_add_arb_if.slave: req0_*/req1_* request channels,
//          res_* result channel, ops_cnt completed-result counter
// Build option: SIGNED_ADD_ARB_SAT_EN - when defined, res_data is clamped to
//   the representable range whenever res_ovf is set; res_ovf is unchanged.

module signed_add_arb #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    signed_add_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           r_state;
    logic             r_last_grant;

    // Latched operation of the current grant
    logic             r_op;
    logic             r_sgn;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_id;

    // Result register
    logic             r_res_valid;
    logic [W-1:0]     r_res_data;
    logic             r_res_id;
    logic             r_res_ovf;
    logic [CNT_W-1:0] r_ops_cnt;

    logic             w_can_grant;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic             w_sel_op;
    logic             w_sel_sgn;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;

    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_raw;
    logic             w_ovf;
    logic [W-1:0]     w_result;

    // ------------------------------------------------------------------
    // Arbitration. A grant is only offered when the result register is
    // free or is being emptied this cycle, so a stalled consumer blocks
    // every new grant. On a tie the requester not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_can_grant = (r_state == IDLE) || ((r_state == DONE) && bus.res_ready);
        w_gnt0      = w_can_grant && bus.req0_valid &&
                      (!bus.req1_valid || r_last_grant);
        w_gnt1      = w_can_grant && bus.req1_valid &&
                      (!bus.req0_valid || !r_last_grant);
        w_any_gnt   = w_gnt0 || w_gnt1;
    end

    always_comb begin
        w_sel_op  = w_gnt1 ? bus.req1_op  : bus.req0_op;
        w_sel_sgn = w_gnt1 ? bus.req1_sgn : bus.req0_sgn;
        w_sel_a   = w_gnt1 ? bus.req1_a   : bus.req0_a;
        w_sel_b   = w_gnt1 ? bus.req1_b   : bus.req0_b;
    end

    // ------------------------------------------------------------------
    // Shared add/sub unit, evaluated on the latched operands at W+1 bits
    // so the carry/borrow is available as bit W.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        w_raw  = r_op ? w_diff[W-1:0] : w_sum[W-1:0];

        w_ovf = 1'b0;
        if (r_sgn) begin
            if (!r_op)
                w_ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
            else
                w_ovf = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
        end else begin
            if (!r_op)
                w_ovf = w_sum[W];
            else
                w_ovf = (r_a < r_b);
        end

`ifdef SIGNED_ADD_ARB_SAT_EN
        w_result = w_raw;
        if (w_ovf) begin
            if (r_sgn)
                // Signed overflow always goes toward the sign of a
                w_result = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else if (!r_op)
                w_result = {W{1'b1}};
            else
                w_result = {W{1'b0}};
        end
`else
        w_result = w_raw;
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_op         <= 1'b0;
            r_sgn        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_id     <= 1'b0;
            r_res_ovf    <= 1'b0;
            r_ops_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_gnt) begin
                        r_op         <= w_sel_op;
                        r_sgn        <= w_sel_sgn;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_state      <= CALC;
                    end
                end

                CALC: begin
                    r_res_data  <= w_result;
                    r_res_id    <= r_id;
                    r_res_ovf   <= w_ovf;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    if (bus.res_ready) begin
                        r_ops_cnt   <= r_ops_cnt + CNT_W'(1);
                        r_res_valid <= 1'b0;
                        // Back-to-back: the next grant is taken in the same
                        // cycle the current result is handed off.
                        if (w_any_gnt) begin
                            r_op         <= w_sel_op;
                            r_sgn        <= w_sel_sgn;
                            r_a          <= w_sel_a;
                            r_b          <= w_sel_b;
                            r_id         <= w_gnt1;
                            r_last_grant <= w_gnt1;
                            r_state      <= CALC;
                        end else begin
                            r_state      <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_id     = r_res_id;
    assign bus.res_ovf    = r_res_ovf;
    assign bus.ops_cnt    = r_ops_cnt;

endmodule

// File: tb/tb_signed_add_arb.sv
// tb/tb_signed_add_arb.sv - directed self-checking bench for signed_add_arb

module tb_signed_add_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signed_add_arb_if #(.W(4), .CNT_W(8)) bus ();

    signed_add_arb #(.W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef SIGNED_ADD_ARB_SAT_EN
    localparam logic [3:0] EXP_USUB = 4'd0;   // 2-5 unsigned, clamped
    localparam logic [3:0] EXP_SSUB = 4'd8;   // -8-1 signed, clamped to -8
    localparam logic [3:0] EXP_UADD = 4'd15;  // 9+9 unsigned, clamped
`else
    localparam logic [3:0] EXP_USUB = 4'd13;
    localparam logic [3:0] EXP_SSUB = 4'd7;
    localparam logic [3:0] EXP_UADD = 4'd2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic op, input logic sgn,
                           input logic [3:0] a, input logic [3:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_sgn = sgn;
            bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_sgn = sgn;
            bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, "_rdy0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
        check({tag, "_rdy1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    endtask

    task automatic check_res(input string tag, input logic [3:0] data, input logic id, input logic ovf);
        check({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
        check({tag, "_data"},  {28'd0, bus.res_data},  {28'd0, data});
        check({tag, "_id"},    {31'd0, bus.res_id},    {31'd0, id});
        check({tag, "_ovf"},   {31'd0, bus.res_ovf},   {31'd0, ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int consumed;
        int cyc;

        clear_inputs();

        // Reset state
        @(negedge clk); #1;
        check("rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_data",  {28'd0, bus.res_data},  32'd0);
        check("rst_id",    {31'd0, bus.res_id},    32'd0);
        check("rst_ovf",   {31'd0, bus.res_ovf},   32'd0);
        check("rst_cnt",   {24'd0, bus.ops_cnt},   32'd0);
        check_ready("rst", 1'b0, 1'b0);
        rst = 1'b0;

        // Single signed add 3+2 from requester 0
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2);
        #1 check_ready("t1_gnt", 1'b1, 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1 check("t1_calc_valid", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk); #1;
        check_res("t1_res", 4'd5, 1'b0, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1 check("t1_cnt", {24'd0, bus.ops_cnt}, 32'd1);
        check("t1_idle_valid", {31'd0, bus.res_valid}, 32'd0);

        // Both requesters always valid, consumer always ready
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd5);
        set_req(1, 1'b1, 1'b1, 1'b1, 4'b1000, 4'd1);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_ready($sformatf("t2_gnt%0d", i), (i % 2) == 0, (i % 2) == 1);
            @(negedge clk); #1;
            check_ready($sformatf("t2_calc%0d", i), 1'b0, 1'b0);
            check($sformatf("t2_calc_valid%0d", i), {31'd0, bus.res_valid}, 32'd0);
            @(negedge clk);
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            if ((i % 2) == 0) check_res($sformatf("t2_r0_%0d", i), EXP_USUB, 1'b0, 1'b1);
            else              check_res($sformatf("t2_r1_%0d", i), EXP_SSUB, 1'b1, 1'b1);
        end
        @(negedge clk); #1;
        check("t2_cnt", {24'd0, bus.ops_cnt}, 32'd4);
        check("t2_idle_valid", {31'd0, bus.res_valid}, 32'd0);

        // Stalled consumer with requester 1 waiting; unsigned 9+9
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd9);
        #1 check_ready("t3_gnt", 1'b1, 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1);
        #1 check_ready("t3_calc", 1'b0, 1'b0);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            #1;
            check_res($sformatf("t3_stall%0d", j), EXP_UADD, 1'b0, 1'b1);
            check_ready($sformatf("t3_stall%0d", j), 1'b0, 1'b0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1 check_ready("t3_release", 1'b0, 1'b1);
        check_res("t3_release", EXP_UADD, 1'b0, 1'b1);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        bus.res_ready = 1'b0;
        #1 check("t3_b2b_valid", {31'd0, bus.res_valid}, 32'd0);
        check("t3_b2b_cnt", {24'd0, bus.ops_cnt}, 32'd5);
        @(negedge clk); #1;
        check_res("t3_r1", 4'd2, 1'b1, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1 check("t3_cnt", {24'd0, bus.ops_cnt}, 32'd6);

        // Reset during CALC; last grant was requester 0 before the reset
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        #1 check("t5_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("t5_rst_cnt", {24'd0, bus.ops_cnt}, 32'd0);
        check("t5_rst_data", {28'd0, bus.res_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd4);
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        #1 check_ready("t5_tie", 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        @(negedge clk); #1;
        check_res("t5_res", 4'd8, 1'b0, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1 check("t5_cnt", {24'd0, bus.ops_cnt}, 32'd1);

        // Counter wrap and back-to-back throughput
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        bus.res_ready = 1'b1;
        consumed = 0;
        cyc = 0;
        while (consumed < 255 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
            if (bus.res_valid) begin
                consumed++;
                if (consumed == 255) bus.req0_valid = 1'b0;
            end
        end
        check("t6_consumed", consumed, 255);
        check("t6_cycles", cyc, 510);
        @(negedge clk); #1;
        check("t6_cnt255", {24'd0, bus.ops_cnt}, 32'd255);
        bus.req0_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("t6_wrap", {24'd0, bus.ops_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_add_arb.md
# signed_add_arb

Two-requester arbiter and sequencer for one shared add/subtract unit with signed and unsigned modes. It accepts operations from two independent valid/ready requesters, grants the shared unit round-robin, computes one result at a time, and holds it in a result register until the consumer accepts it. It sits between the control-side requesters and the downstream result consumer, replacing per-requester adder instances.

## Interface
Parameters:
- W, 4, operand and result width in bits (two's complement in signed mode)
- CNT_W, 8, width of the completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  1  0 = a+b, 1 = a−b
- req0_sgn  in  1  1 = signed, 0 = unsigned
- req0_a, req0_b  in  W  operands
- req1_valid, req1_ready, req1_op, req1_sgn, req1_a, req1_b: same as requester 0, for requester 1
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  consumer accepts the result
- res_data  out  W  result
- res_id  out  1  requester that issued the result
- res_ovf  out  1  signed overflow, or unsigned carry-out (add) / borrow (sub)
- ops_cnt  out  CNT_W  count of completed result handshakes

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: arbitrate among valid requests. The winner's reqN_ready is 1 combinationally. On the handshake, latch op, sgn, a, b and id, then go to CALC. With no request, stay in IDLE.
- CALC: compute from the latched operands, write res_data/res_id/res_ovf, set res_valid, go to DONE. Both reqN_ready are 0.
- DONE: res_valid is 1.
  - res_ready=0: hold all outputs stable and keep both reqN_ready at 0.
  - res_ready=1 with a request pending: arbitrate in the same cycle, the winner gets reqN_ready=1, latch its operation, clear res_valid, go to CALC (back-to-back).
  - res_ready=1 with no request: clear res_valid and go to IDLE.
- Arbitration is round-robin on last_grant:
  - Both valid: grant the requester not granted last.
  - One valid: grant that requester.
  - last_grant updates only on an actual request handshake.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Requesters hold valid and payload stable until ready. The arbiter never withdraws a grant within a cycle.
- Arithmetic is computed at width W+1, and res_data is the low W bits.
  - Unsigned add: res_ovf = bit W of a+b.
  - Unsigned sub: res_ovf = (a<b).
  - Signed add: res_ovf = (a[W−1]==b[W−1]) && (sum[W−1]!=a[W−1]).
  - Signed sub: res_ovf = (a[W−1]!=b[W−1]) && (diff[W−1]!=a[W−1]).
- ops_cnt increments on each res_valid&&res_ready and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: state IDLE, res_valid 0, res_data 0, res_id 0, res_ovf 0, ops_cnt 0, last_grant 1, reqN_ready 0 (combinational, low while no grant).
- Latency: request handshake at edge k → res_valid=1 after edge k+1.
- Throughput:
  - One result per 2 cycles when the consumer is always ready.
  - A stalled consumer blocks all new grants.
- A simultaneous res handshake and new request grant in DONE takes the back-to-back path. The result is not lost and ops_cnt counts it.
- Reset asserted mid-operation (CALC or DONE) discards the latched operation and any unconsumed result. All outputs take reset values immediately.

## Configuration
- SIGNED_ADD_ARB_SAT_EN defined: when res_ovf=1, res_data is clamped:
  - signed overflow → 2^(W−1)−1 if a was non-negative, else −2^(W−1)
  - unsigned add → 2^W−1
  - unsigned sub → 0
  - res_ovf still reports the overflow.
- Not defined: res_data is the wrapped W-bit result. res_ovf behaves identically in both builds.

## Test plan
- Reset, then req0 signed add a=3, b=2 → req0_ready at the first cycle; res_valid 2 cycles later; res_data=5, res_id=0, res_ovf=0; ops_cnt=1 after consume.
- Both requests valid every cycle, res_ready=1: req0 unsigned sub 2−5, req1 signed sub −8−1.
  - Grants alternate 0,1,0,1.
  - req0 result: res_data=13, res_ovf=1.
  - req1 result, without SAT: res_data=7, res_ovf=1.
  - req1 result, with SAT: res_data=−8 (4'b1000).
- res_ready held 0 for 5 cycles in DONE while req1 is valid → result stable, both reqN_ready=0; on res_ready=1, req1 is granted in that same cycle.
- Unsigned add 9+9, with and without SIGNED_ADD_ARB_SAT_EN → res_ovf=1; res_data=2 without SAT, 15 with SAT.
- Assert rst for one cycle during CALC → res_valid=0 and ops_cnt=0 immediately; the next tie is granted to requester 0.
- 256 consumed results with CNT_W=8 → ops_cnt wraps to 0.
